// File: rtl/pattern_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_pkg
// Description : Shared types and defaults for the pattern scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [3:0] PAT_RST_DEFAULT = 4'b1010;
    localparam int         WORD_W_DEFAULT  = 16;
    localparam int         IDX_W           = $clog2(WORD_W_DEFAULT);

    // Index width for an arbitrary word width; never narrower than one bit.
    function automatic int idx_width(input int word_w);
        return (word_w < 2) ? 1 : $clog2(word_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_pat_det.sv
`default_nettype none
// ============================================================================
// Module      : serial_pat_det
// Description : Bit-serial overlapping sequence detector with arming counter.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pat_det
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bit,
    input  logic             i_bit_en,
    input  logic             i_clear,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_match
);

    localparam int                SEEN_W   = $clog2(PAT_W + 1);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);
    localparam logic [SEEN_W-1:0] SEEN_ARM = SEEN_W'(PAT_W - 1);

    logic [PAT_W-1:0]  w_cand;
    logic [SEEN_W-1:0] r_seen;

    generate
        if (PAT_W > 1) begin : g_shift
            logic [PAT_W-2:0] r_hist;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hist <= '0;
                end else if (i_clear) begin
                    r_hist <= '0;
                end else if (i_bit_en) begin
                    r_hist <= w_cand[PAT_W-2:0];
                end
            end

            assign w_cand = {r_hist, i_bit};
        end else begin : g_single
            assign w_cand = i_bit;
        end
    endgenerate

    // The arming count keeps reset-valued history from producing a match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= '0;
        end else if (i_clear) begin
            r_seen <= '0;
        end else if (i_bit_en && (r_seen != SEEN_MAX)) begin
            r_seen <= r_seen + 1'b1;
        end
    end

    assign o_match = i_bit_en && (w_cand == i_pattern) && (r_seen >= SEEN_ARM);

endmodule
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_ctrl
// Description : Frame controller: serialises words MSB-first into the
//               detector, counts matches per frame and reports the count.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int               WORD_W  = WORD_W_DEFAULT,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              busy
);

    localparam int               IDX_W_L = idx_width(WORD_W);
    localparam logic [IDX_W_L-1:0] IDX_TOP = IDX_W_L'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_word;
    logic                r_last;
    logic [IDX_W_L-1:0]  r_idx;
    logic                r_frame_open;
    logic [CNT_W-1:0]    r_count;
    logic                r_sat;
    logic [PAT_W-1:0]    r_pat;

    logic w_idle;
    logic w_shift;
    logic w_last_bit;
    logic w_xfer;
    logic w_out_hs;
    logic w_cfg_ok;
    logic w_match;

    assign w_idle     = (r_state == S_IDLE);
    assign w_shift    = (r_state == S_SHIFT);
    assign w_last_bit = (r_idx == '0);

    // in_ready is forced low while reset is held even though the state is IDLE.
    assign in_ready  = w_idle && rst_n;
    assign out_valid = (r_state == S_REPORT);
    assign out_count = r_count;
    assign out_sat   = r_sat;
    assign busy      = r_frame_open || !w_idle;

    assign w_xfer   = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;
    assign w_cfg_ok = cfg_we && w_idle && !r_frame_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = r_last ? S_REPORT : S_IDLE;
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_last       <= 1'b0;
            r_idx        <= '0;
            r_frame_open <= 1'b0;
            r_count      <= '0;
            r_sat        <= 1'b0;
            r_pat        <= PAT_RST;
        end else begin
            // A write in the same cycle as a transfer lands before the first shift.
            if (w_cfg_ok) begin
                r_pat <= cfg_pat;
            end
            if (w_xfer) begin
                r_word       <= in_data;
                r_last       <= in_last;
                r_idx        <= IDX_TOP;
                r_frame_open <= 1'b1;
            end
            if (w_shift && !w_last_bit) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_match) begin
                if (r_count == CNT_MAX) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_out_hs) begin
                r_count      <= '0;
                r_sat        <= 1'b0;
                r_frame_open <= 1'b0;
            end
        end
    end

    serial_pat_det #(
        .PAT_W (PAT_W)
    ) u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bit     (r_word[r_idx]),
        .i_bit_en  (w_shift),
        .i_clear   (w_out_hs),
        .i_pattern (r_pat),
        .o_match   (w_match)
    );

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_ctrl
// Description : Directed self-checking bench for pattern_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pat;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_ready;

    logic              in_ready,  in_ready_s;
    logic              out_valid, out_valid_s;
    logic [7:0]        out_count;
    logic [2:0]        out_count_s;
    logic              out_sat,   out_sat_s;
    logic              busy,      busy_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_sat(out_sat), .busy(busy)
    );

    // Narrow-counter twin driven by the same stimulus, used for saturation.
    pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_count(out_count_s), .out_sat(out_sat_s), .busy(busy_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic last,
                             input logic cfg_at_xfer, input logic cfg_mid);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (cfg_at_xfer) begin
            cfg_we  = 1'b1;
            cfg_pat = 4'b0000;
        end
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (cfg_mid && i == 5) begin
                cfg_we  = 1'b1;
                cfg_pat = 4'b0000;
            end else begin
                cfg_we = 1'b0;
            end
            if (i == WORD_W - 1) chk("shift_in_ready_low", in_ready, 0);
            tick();
        end
        cfg_we = 1'b0;
        if (last) chk("report_valid", out_valid, 1);
        else      chk("between_words_ready", in_ready, 1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid_low", out_valid, 0);
        chk("hs_busy_low", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pat = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", out_count, 0);
        chk("rst_sat", out_sat, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Single match with reset pattern 1010
        send_word(16'hA000, 1'b1, 1'b0, 1'b0);
        chk("a000_count", out_count, 1);
        chk("a000_sat", out_sat, 0);
        take_result();

        // Overlapping matches
        send_word(16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("aaaa_count", out_count, 7);
        chk("aaaa_count_narrow", out_count_s, 7);
        chk("aaaa_sat_narrow", out_sat_s, 0);
        take_result();

        // Match straddling a word boundary
        send_word(16'h0005, 1'b0, 1'b0, 1'b0);
        chk("open_frame_busy", busy, 1);
        send_word(16'h0000, 1'b1, 1'b0, 1'b0);
        chk("cross_count", out_count, 1);
        take_result();

        // Saturation on the 3-bit counter, 15 matches on the 8-bit one
        send_word(16'hAAAA, 1'b0, 1'b0, 1'b0);
        send_word(16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("two_word_count", out_count, 15);
        chk("two_word_sat", out_sat, 0);
        chk("sat_count_narrow", out_count_s, 7);
        chk("sat_flag_narrow", out_sat_s, 1);
        take_result();
        chk("sat_cleared_narrow", out_sat_s, 0);

        // Config writes inside an open frame are ignored
        send_word(16'hA000, 1'b0, 1'b0, 1'b1);
        send_word(16'hA000, 1'b1, 1'b1, 1'b1);
        chk("locked_cfg_count", out_count, 2);

        // Backpressure: result holds while out_ready is low
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_count", out_count, 2);
            chk("bp_in_ready", in_ready, 0);
        end
        take_result();

        // Pattern write coincident with the transfer applies to that word
        send_word(16'h0000, 1'b1, 1'b1, 1'b0);
        chk("zero_pat_count", out_count, 13);
        take_result();

        // Reset in the middle of a frame
        in_valid = 1'b1; in_data = 16'h0000; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", out_count, 0);
        tick(); tick();
        chk("midrst_hold_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        send_word(16'hA000, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pattern_count", out_count, 1);
        take_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Frame-level controller that sequences a serial pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises each one MSB-first, one bit per clock, into a programmable PAT_W-bit sequence detector.
- Counts overlapping matches across all words of a frame and returns the count over a second valid/ready handshake.
- Sits between a word-oriented producer and the bit-serial detection datapath.

Parameters:
- WORD_W, 16, width of each input word (bits shifted per word); must be at least 2.
- PAT_W, 4, pattern length in bits; must be between 1 and WORD_W.
- CNT_W, 8, width of the match counter.
- PAT_RST, 4'b1010, pattern value loaded at reset; width PAT_W.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  pattern write strobe.
- cfg_pat  in  PAT_W  new pattern value.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WORD_W  word to scan, MSB first.
- in_last  in  1  word is the last of its frame.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer takes the result.
- out_count  out  CNT_W  matches in the frame.
- out_sat  out  1  counter saturated during the frame.
- busy  out  1  a frame is open or a result is pending.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, port rst_n.
- Reset state: FSM to IDLE; in_ready=0 during reset and 1 in IDLE; out_valid=0; out_count=0; out_sat=0; busy=0; pattern register=PAT_RST; history, seen-count and bit index cleared.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - An in_valid&in_ready transfer latches in_data and in_last, sets bit index to WORD_W-1, sets frame_open=1, and moves to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle one bit, data[idx], enters history: history <= {history[PAT_W-2:0], bit}.
  - seen increments, saturating at PAT_W.
  - Match condition: ({history[PAT_W-2:0], bit} == pattern) and (seen+1 >= PAT_W). Matches overlap.
  - On a match the counter increments, saturating at 2^CNT_W-1. An increment attempted at max sets the sticky sat flag.
  - After the bit at idx 0:
    - If in_last was latched, go to REPORT.
    - Otherwise go to IDLE. History, seen and count persist, so a pattern may straddle a word boundary.
  - Latency: exactly WORD_W cycles per word. The earliest next in_ready is the cycle after the final shift.
- REPORT:
  - out_valid=1; out_count and out_sat are held stable; in_ready=0.
  - On out_valid&out_ready: clear count, sat, history, seen and frame_open, and go to IDLE.
  - The next word may be accepted the cycle after the handshake.
- busy = frame_open | (state != IDLE).
- Configuration:
  - cfg_we takes effect only when state==IDLE and frame_open==0. Otherwise it is ignored and no pattern change occurs mid-frame.
  - If cfg_we and an input transfer occur in the same IDLE cycle, the new pattern applies to that word.
- No spurious matches: the seen gating prevents reset-valued history from matching, e.g. with pattern 0000.
- Reset asserted mid-SHIFT or mid-REPORT aborts the frame immediately. The pending result is lost and the pattern returns to PAT_RST.

Decomposition:
- Package pattern_scan_pkg holds:
  - the state enum (IDLE/SHIFT/REPORT);
  - the PAT_RST default;
  - a localparam for index width, $clog2(WORD_W).
- Sub-module serial_pat_det holds:
  - the history shift register, seen counter and comparator;
  - inputs: bit, bit_en, clear, pattern;
  - output: match (combinational on the current bit).
- The controller owns the FSM, the word latch, the counter and the handshakes.

Test Plan:
- Default pattern 1010; send 16'hA000 with in_last -> after 16 SHIFT cycles, out_valid with out_count=1, out_sat=0.
- Send 16'hAAAA with in_last -> out_count=7 (overlapping matches ending at bits 4,6,…,16).
- Cross-word: 16'h0005 (not last), then 16'h0000 with last -> out_count=1, from a match straddling the boundary.
- Saturation with CNT_W=3: 16'hAAAA then 16'hAAAA with last -> out_count=7, out_sat=1.
- Backpressure and config lock:
  - Hold out_ready=0 for 5 cycles in REPORT -> out_valid and out_count stable, in_ready=0.
  - A cfg_we pulse mid-frame is ignored.
  - After the handshake, write cfg_pat=4'b0000 and send 16'h0000 with last -> count=13.
- Reset: assert rst_n=0 during SHIFT at bit 7 -> in_ready=0 while reset is held, out_valid=0, busy=0, pattern back to 1010; the next frame of 16'hA000 with last counts 1.
